// File: rtl/mux_read_arbiter_pkg.sv
// Shared types, default sizes and helpers for the round-robin read-mux arbiter.
package muxarb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam int N_DEF    = 4;
    localparam int ADDR_DEF = 12;
    localparam int R_DEF    = 4;
    localparam int MAX_R    = 32;

    // Callers size the result down to their own requester count.
    function automatic logic [MAX_R-1:0] onehot(input int idx);
        onehot = {{(MAX_R-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/mux_read_arbiter_rr_arbiter_n.sv
// Combinational round-robin pick: first set request starting at ptr, wrapping modulo R.
module rr_arbiter_n #(
    parameter int R  = 4,
    parameter int PW = $clog2(R)
) (
    input  logic [R-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] winner,
    output logic          valid
);

    logic [PW-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = ptr;
        for (int i = 0; i < R; i++) begin
            if (!valid && req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
            idx = (idx == PW'(R - 1)) ? '0 : idx + PW'(1);
        end
    end

endmodule

// File: rtl/mux_read_arbiter.sv
// Round-robin arbiter sharing one deep combinational read mux among R requesters.
// Optional macro MUXARB_LOCK_EN adds lock_i so an owner can keep priority for bursts.
module mux_read_arbiter
    import muxarb_pkg::*;
#(
    parameter int n       = N_DEF,
    parameter int address = ADDR_DEF,
    parameter int R       = R_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
`ifdef MUXARB_LOCK_EN
    input  logic [R-1:0]       lock_i,
`endif
    input  logic [R-1:0]       req_i,
    input  logic [address-1:0] addr_i [0:R-1],
    output logic [R-1:0]       gnt_o,
    output logic [address-1:0] sel_o,
    input  logic [n-1:0]       mux_data_i,
    output logic [n-1:0]       rdata_o,
    output logic [R-1:0]       rvalid_o,
    output logic               busy_o
);

    localparam int PW = $clog2(R);

    state_t             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      owner_q, owner_d;
    logic [address-1:0] sel_q, sel_d;
    logic [n-1:0]       rdata_q, rdata_d;
    logic [R-1:0]       gnt_q, gnt_d;
    logic [R-1:0]       rvalid_q, rvalid_d;

    logic [PW-1:0]      winner;
    logic               win_valid;
    logic [PW-1:0]      owner_next;
    logic               keep_ptr;

    rr_arbiter_n #(
        .R  (R),
        .PW (PW)
    ) u_rr (
        .req    (req_i),
        .ptr    (ptr_q),
        .winner (winner),
        .valid  (win_valid)
    );

    assign owner_next = (owner_q == PW'(R - 1)) ? '0 : owner_q + PW'(1);

`ifdef MUXARB_LOCK_EN
    assign keep_ptr = lock_i[owner_q];
`else
    assign keep_ptr = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        sel_d    = sel_q;
        rdata_d  = rdata_q;
        gnt_d    = '0;
        rvalid_d = '0;
        case (state_q)
            IDLE: begin
                // addr_i is only sampled here; sel stays frozen until the next grant.
                if (win_valid) begin
                    sel_d   = addr_i[winner];
                    owner_d = winner;
                    gnt_d   = R'(onehot(int'(winner)));
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                rdata_d  = mux_data_i;
                rvalid_d = R'(onehot(int'(owner_q)));
                ptr_d    = keep_ptr ? owner_q : owner_next;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            sel_q    <= '0;
            rdata_q  <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            sel_q    <= sel_d;
            rdata_q  <= rdata_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign gnt_o    = gnt_q;
    assign sel_o    = sel_q;
    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
    assign busy_o   = (state_q != IDLE);

endmodule

// File: doc/mux_read_arbiter.md
Name: mux_read_arbiter

Overview:
- Shares one wide n-bit, 2^address-entry read mux (for example the 4096:1 register/memory read path) among R requesters.
- Arbitrates round-robin, drives the mux select from a register, and waits one cycle for the deep combinational mux tree to settle.
- Captures the mux output into a register and returns it to the granted requester with a one-cycle valid pulse.
- Sits between the requesting units and the mux; the mux itself stays purely combinational.

Parameters:
- n, 4: data width of the mux.
- address, 12: select width (mux depth m = 2^address).
- R, 4: number of requesters (≥2).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_i  in  R  per-requester read request; held until the requester sees its gnt_o bit.
- addr_i  in  R×address  per-requester read address (unpacked array [0:R-1]).
- gnt_o  out  R  one-hot grant pulse, 1 cycle.
- sel_o  out  address  registered select to the mux.
- mux_data_i  in  n  mux output data_o.
- rdata_o  out  n  captured read data; valid only when rvalid_o is non-zero.
- rvalid_o  out  R  one-hot read-data-valid pulse, 1 cycle.
- busy_o  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (async, any time, including mid-transaction):
  - state=IDLE; ptr=0; owner=0.
  - sel_o, rdata_o, gnt_o, rvalid_o, busy_o all 0.
  - The aborted transaction never produces rvalid_o.
- States: IDLE → SETTLE → CAPTURE → IDLE.
- IDLE, req_i==0: state and outputs unchanged.
- IDLE, req_i≠0:
  - Winner w = first set req_i bit searching ptr, ptr+1, …, R-1, 0, …, ptr-1 (wraps modulo R).
  - At the edge: sel_o←addr_i[w]; owner←w; gnt_o←onehot(w); state←SETTLE.
  - addr_i is sampled only at this edge.
- SETTLE: sel_o is stable; gnt_o is high for exactly this cycle. At the edge: gnt_o←0; state←CAPTURE.
- CAPTURE: at the edge:
  - rdata_o←mux_data_i; rvalid_o←onehot(owner).
  - ptr←(owner+1) mod R; state←IDLE.
- Next cycle (back in IDLE): rvalid_o pulses, and a new arbitration may occur in the same cycle.
- rvalid_o clears after one cycle. rdata_o holds its value until the next CAPTURE.
- Latency and throughput:
  - req seen in IDLE at cycle t → gnt_o at t+1, rvalid_o/rdata_o at t+3.
  - Maximum throughput is one read per 3 cycles.
- Requester rules:
  - req_i dropped before grant simply withdraws the request; arbitration is re-evaluated every IDLE cycle.
  - req_i still high in the cycle after gnt_o is treated as a new request.
  - req_i changes during SETTLE/CAPTURE are ignored.
- All requests active: strict rotation 0,1,…,R-1,0 with no starvation. A single requester is granted back-to-back every 3 cycles.
- sel_o changes only at the IDLE→SETTLE edge, so the mux input is never disturbed during settle or capture.

Optional Feature:
- Macro: MUXARB_LOCK_EN.
- Defined:
  - Adds input lock_i[R].
  - If lock_i[owner]=1 at the CAPTURE edge, ptr←owner instead of owner+1, so the owner keeps priority for back-to-back reads (burst of sequential reads).
  - Reset and timing are otherwise unchanged.
- Undefined: lock_i does not exist; ptr always advances.

Decomposition:
- Package muxarb_pkg:
  - state enum {IDLE, SETTLE, CAPTURE} (2-bit).
  - Default constants N_DEF=4, ADDR_DEF=12, R_DEF=4.
  - Function onehot().
- Sub-module rr_arbiter_n#(R): purely combinational.
  - Inputs req, ptr. Outputs winner index and valid.
  - Instantiated once; this block contains the FSM and registers.

Test Plan:
- Reset mid-SETTLE (rst_i pulsed while the owner holds a grant) → all outputs 0 immediately; no rvalid_o afterwards; the next req_i=0001 is granted to 0.
- Single read: req_i=0010, addr_i[1]=12'h0A5, mux model returns data_i[h0A5]=4'hC → gnt_o=0010 at t+1, sel_o=h0A5 from t+1, rvalid_o=0010 with rdata_o=4'hC at t+3.
- Fairness: req_i=1111 held continuously → grants 0,1,2,3,0 at 3-cycle spacing, and each rvalid_o matches its grant.
- Wrap/priority: ptr=3 (after a grant to 2), req_i=1001 → requester 3 granted, then requester 0.
- Withdraw: req_i=0100 for one IDLE cycle, dropped while another request is in flight → no grant to requester 2.
- With MUXARB_LOCK_EN: req_i=0011, lock_i[0]=1 → requester 0 granted repeatedly. Dropping lock_i[0] → the next grant goes to requester 1.
